serial_bit_feeder: RTL
======================

# serial_bit_feeder

Parallel-to-serial front end that accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on a serial output. It sits directly upstream of the serial pattern-detector stage: `dout` drives the detector's single-bit `din`, and `dout_valid` qualifies it. A one-word holding register allows back-to-back words to be shifted with no idle gap.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- IDLE_BIT, 1'b0, value driven on `dout` whenever no bit is being presented.

- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset: synchronous, active-low.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  the holding register can accept a word.
- enable  input  1  shift enable; low freezes the shifter.
- dout  output  1  current serial bit.
- dout_valid  output  1  `dout` carries a real data bit this cycle.
- dout_last  output  1  `dout` is the final bit of its word (qualified by `dout_valid`).
- busy  output  1  the shifter or the holding register is occupied.

## Operation
- Storage:
  - Holding register `hold` with flag `hold_full`.
  - Shift register `shreg` and bit counter `bit_cnt` (clog2(WIDTH) bits).
  - Two-state FSM: IDLE and SHIFT.
- Accept rules:
  - A word is accepted when `in_valid && in_ready` at a rising edge. It is written to `hold`, and `hold_full` is set.
  - `in_ready = resetn && !hold_full`.
- IDLE:
  - If `hold_full && enable`, load `shreg <= hold`, clear `hold_full` and `bit_cnt`, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, when `enable` is high:
  - Each edge advances `shreg` by one bit and increments `bit_cnt`.
  - At `bit_cnt == WIDTH-1`:
    - If `hold_full`, reload `shreg` from `hold`, clear `hold_full`, reset `bit_cnt` to 0, and stay in SHIFT. There is no gap between words.
    - Otherwise go to IDLE.
- SHIFT, when `enable` is low: `shreg`, `bit_cnt` and the state hold their values. `hold` can still accept a word.
- Outputs:
  - `dout_valid = (state == SHIFT) && enable`.
  - `dout` is the bit currently selected from `shreg` while in SHIFT, and `IDLE_BIT` in IDLE.
  - `dout_last = dout_valid && (bit_cnt == WIDTH-1)`.
  - `busy = (state == SHIFT) || hold_full`.
- Simultaneous events:
  - When `hold` is drained at the same edge a new word is offered, the new word is not accepted, because `in_ready` was already low that cycle.
  - Sustained throughput is still one word per WIDTH cycles: `in_ready` rises the cycle after the drain, and WIDTH ≥ 2 leaves time to refill.

## Timing
- Reset (resetn low at an edge):
  - State goes to IDLE; `hold_full`, `bit_cnt` and `shreg` go to 0.
  - Outputs: `in_ready` = 0 while reset is held; `dout` = IDLE_BIT; `dout_valid`, `dout_last` and `busy` = 0.
  - A reset mid-word discards both the in-flight word and the held word, with no partial flush.
- Latency: a word accepted at edge E0 is loaded at E1 (given `enable`). Its first bit appears on `dout` after E1 and persists for one cycle per enabled edge.
- A word occupies exactly WIDTH enabled cycles on `dout`.
- `in_ready` returns high on the edge that moves `hold` into `shreg`.
- `dout`, `dout_valid` and `dout_last` are decoded combinationally from registered state and `enable`. There is no combinational path from `in_*` to `dout*`.

## Configuration
- `SERIAL_FEEDER_LSB_FIRST_EN`:
  - Defined: bits are emitted LSB first; `shreg` shifts right and `dout = shreg[0]`.
  - Undefined (default): bits are emitted MSB first; `shreg` shifts left and `dout = shreg[WIDTH-1]`.
  - The handshake, timing and `dout_last` position are identical in both modes.

## Test plan
- Single word, MSB first: accept 8'hA5 with `enable`=1.
  - `dout` = 1,0,1,0,0,1,0,1 over 8 cycles with `dout_valid`=1.
  - `dout_last` is high only on the 8th bit.
  - Then `dout`=IDLE_BIT, `dout_valid`=0, `busy`=0.
- Back-to-back: offer 8'hA0, 8'h5F, 8'hFF continuously.
  - 24 consecutive valid bits with no gap.
  - `in_ready` is low whenever `hold_full`; each word is accepted exactly once.
- Stall: deassert `enable` for 3 cycles after bit 3 of 8'hC3.
  - `dout_valid`=0 and `dout` is frozen during the stall.
  - The remaining bits resume in order; the total number of valid bits is 8.
- Reset mid-word: pull resetn low at bit 5 of 8'hF0 with 8'h0F held.
  - All outputs are at their reset values the next cycle.
  - After release, nothing is emitted until a new word is accepted.
- Detector chain: feed 8'hAA into the downstream detector.
  - `dout` stream 10101010 yields detector pulses after bits 4, 6 and 8 (overlapping match).
- Macro on: 8'hA5 emits 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 (palindromic check). Then repeat with 8'h01, which emits 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end with a one-word holding register for gap-free streaming.
// Build option: define SERIAL_FEEDER_LSB_FIRST_EN to emit LSB first (default is MSB first).
module serial_bit_feeder #(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enable,
   output logic             dout,
   output logic             dout_valid,
   output logic             dout_last,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             accept;
   logic             at_last;

   // Advance the shifter by one bit in the configured emission order.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
      return {1'b0, s[WIDTH-1:1]};
`else
      return {s[WIDTH-2:0], 1'b0};
`endif
   endfunction

   function automatic logic current_bit(input logic [WIDTH-1:0] s);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
      return s[0];
`else
      return s[WIDTH-1];
`endif
   endfunction

   assign in_ready = resetn && !hold_full_q;
   assign accept   = in_valid && in_ready;
   assign at_last  = (bit_cnt_q == LAST_CNT);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;

      // A drain and an accept never coincide: in_ready is low while hold is full.
      if (accept) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (hold_full_q && enable) begin
               shreg_d     = hold_q;
               hold_full_d = 1'b0;
               bit_cnt_d   = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (enable) begin
               if (at_last) begin
                  if (hold_full_q) begin
                     shreg_d     = hold_q;
                     hold_full_d = 1'b0;
                     bit_cnt_d   = '0;
                  end else begin
                     shreg_d   = shift_once(shreg_q);
                     bit_cnt_d = '0;
                     state_d   = IDLE;
                  end
               end else begin
                  shreg_d   = shift_once(shreg_q);
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
      end
   end

   // Holding data is only ever consumed under hold_full, so it needs no reset.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign dout_valid = (state_q == SHIFT) && enable;
   assign dout       = (state_q == SHIFT) ? current_bit(shreg_q) : IDLE_BIT;
   assign dout_last  = dout_valid && at_last;
   assign busy       = (state_q == SHIFT) || hold_full_q;

endmodule
